// File: rtl/cla_chunk_sequencer.sv
// rtl/cla_chunk_sequencer.sv - chunked operand sequencer feeding the decomposed CLA adder
module cla_chunk_sequencer #(
  parameter  int NBIT   = 4,
  parameter  int NCHUNK = 4,
  localparam int WIDTH  = NBIT * NCHUNK,
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [NBIT-1:0]  add_a,
  output logic [NBIT-1:0]  add_b,
  output logic             add_c,
  input  logic [NBIT-1:0]  add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx;
  logic             last_chunk;
  logic             accept;

  assign last_chunk = (idx == IDXW'(NCHUNK - 1));
  assign req_ready  = (state_q == IDLE);
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign accept     = req_valid & req_ready;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept in IDLE, walk chunks in RUN, hold result in DONE until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (res_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Current chunk to the adder; zero whenever the adder is not in use
  always_comb begin
    add_a = '0;
    add_b = '0;
    add_c = 1'b0;
    if (state_q == RUN) begin
      add_a = a_q[idx*NBIT +: NBIT];
      add_b = b_q[idx*NBIT +: NBIT];
      add_c = carry_q;
    end
  end

  // Operand capture, carry chaining and result assembly, LSB chunk first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= op_cin;
            idx     <= '0;
            result  <= '0;
            cout    <= 1'b0;
          end
        end
        RUN: begin
          result[idx*NBIT +: NBIT] <= add_sum;
          carry_q                  <= add_cout;
          if (last_chunk) begin
            cout <= add_cout;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cla_chunk_sequencer.md
Name: cla_chunk_sequencer

Overview:
- Upstream operand stage for the decomposed CLA adder (nonlinear part plus linear part).
- Accepts one wide addition request, splits both operands into NBIT-bit chunks, and drives one chunk per cycle into the adder's a/b/c inputs.
- Each cycle it captures the adder's sum and carry-out, chains the carry into the next chunk, and assembles the full-width result behind a valid/ready handshake.

Parameters:
- NBIT, 4, chunk width; must match the adder's NBIT.
- NCHUNK, 4, number of chunks per operation (≥1); WIDTH = NBIT*NCHUNK (default 16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- op_a  input  WIDTH  operand A, sampled on accept.
- op_b  input  WIDTH  operand B, sampled on accept.
- op_cin  input  1  carry-in, sampled on accept.
- add_a  output  NBIT  chunk of A to the adder.
- add_b  output  NBIT  chunk of B to the adder.
- add_c  output  1  chunk carry-in to the adder.
- add_sum  input  NBIT  adder sum for the current chunk (combinational return path).
- add_cout  input  1  adder carry-out for the current chunk.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- result  output  WIDTH  assembled sum.
- cout  output  1  final carry-out (overflow).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock, reset and state:
  - One clock: clk. Reset rst_n is asynchronous and active-low.
  - FSM states: IDLE, RUN, DONE. Internal registers: a_q, b_q (WIDTH), carry_q, idx (chunk counter, clog2(NCHUNK) bits, min 1).
- Reset values: state=IDLE, a_q=b_q=0, carry_q=0, idx=0, result=0, cout=0, res_valid=0. Reset mid-operation aborts immediately and discards partial results.
- req_ready = (state==IDLE). res_valid = (state==DONE). busy = (state!=IDLE).
- IDLE:
  - Accept occurs when req_valid & req_ready at a clock edge.
  - On accept: a_q<=op_a, b_q<=op_b, carry_q<=op_cin, idx<=0, result<=0, cout<=0, then go to RUN.
- RUN:
  - add_a=a_q[idx*NBIT +: NBIT], add_b=b_q[idx*NBIT +: NBIT], add_c=carry_q. These are combinational from registers only.
  - Each edge: result[idx*NBIT +: NBIT]<=add_sum, carry_q<=add_cout.
  - If idx==NCHUNK-1: cout<=add_cout and go to DONE. Otherwise idx<=idx+1.
  - Adder path add_a/b/c → add_sum/cout must settle within one clk period. No wait states.
- Outside RUN: add_a, add_b and add_c drive 0.
- DONE:
  - result and cout stay stable while res_valid=1 and res_ready=0. Backpressure is unbounded.
  - On res_ready=1, go to IDLE. result and cout keep their last value until the next accept.
- Latency: accept at edge E0, res_valid high after edge E0+NCHUNK (NCHUNK RUN cycles). Minimum spacing between accepts is NCHUNK+2 cycles. No overlap: new requests are not accepted in DONE.
- req_valid while busy: ignored, not queued. The requester must hold the request until req_ready.
- Arithmetic: result = (op_a+op_b+op_cin) mod 2^WIDTH; cout = bit WIDTH of the full sum. Carry is chained strictly LSB chunk first.
- NCHUNK=1: a single RUN cycle, then DONE.
- Operand inputs are don't-care except at the accept edge.

Test Plan:
- The bench drives add_sum/add_cout from a behavioural NBIT adder: {add_cout,add_sum}=add_a+add_b+add_c. One run repeats the scenarios with the real decomposed adder.
- Basic add: op_a=0x1234, op_b=0x4321, op_cin=0 → after 4 RUN cycles res_valid=1, result=0x5555, cout=0. add_a must show sequence 4,3,2,1.
- Full ripple: op_a=0xFFFF, op_b=0x0001, op_cin=0 → result=0x0000, cout=1. add_c must show sequence 0,1,1,1.
- Carry-in only: op_a=0, op_b=0, op_cin=1 → result=0x0001, cout=0. Also op_a=0xFFFF, op_b=0, op_cin=1 → result=0x0000, cout=1.
- Backpressure and busy: hold res_ready=0 for 5 cycles after res_valid.
  - result=0x5555 must stay stable; req_ready=0.
  - A second req_valid pulse during this window must be ignored.
  - After res_ready=1, go to IDLE next cycle; the next request 0x000A+0x0006 → 0x0010.
- Reset mid-op: assert rst_n=0 while idx=2 → outputs immediately 0, state IDLE. After release, 0x8000+0x8000 → result=0x0000, cout=1.
- Parameter sweep: NBIT=4/NCHUNK=1 with 0x9+0x9 → result=0x2, cout=1. NBIT=8/NCHUNK=2 with 0x00FF+0x0001 → 0x0100, cout=0.
